sos_output_quantize: RTL and testbench
======================================

Name: sos_output_quantize

Overview:
- Output-side width reducer for the cascade SOS IIR datapath: takes a wide L_WD accumulator sample and returns it to the S_WD sample domain.
- Applies a fixed right shift with round-half-up, then saturates per sample as signed or unsigned.
- Two-stage valid/ready pipeline between the last SOS section and the sample output port.
- Provides a per-sample saturation flag, a sticky flag and a saturating event counter for overflow monitoring.

Parameters:
- L_WD, 32: input (accumulator) width.
- S_WD, 16: output sample width.
- SHIFT, 14: fractional bits discarded; 0 <= SHIFT < L_WD, and L_WD-SHIFT >= S_WD (elaboration-time assertion).
- CNT_WD, 16: saturation counter width.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  asynchronous reset, active-high.
- data_i  in  L_WD  accumulator sample.
- signed_i  in  1  1 = data_i and data_o are two's complement; 0 = unsigned.
- valid_i  in  1  input sample valid.
- ready_o  out  1  block can accept data_i this cycle.
- data_o  out  S_WD  quantized sample.
- sat_o  out  1  data_o was clipped; aligned with data_o.
- valid_o  out  1  output sample valid.
- ready_i  in  1  downstream accepts data_o.
- clr_i  in  1  synchronous clear of sat_sticky_o and sat_cnt_o.
- sat_sticky_o  out  1  set by any saturated output handshake.
- sat_cnt_o  out  CNT_WD  number of saturated output handshakes, clamped at all-ones.

Behaviour:
- Reset (async, rst_i=1): valid_o=0, data_o=0, sat_o=0, sat_sticky_o=0, sat_cnt_o=0; internal stage-1 valid=0. Reset mid-stream discards in-flight samples.
- Pipeline enable: en = ~valid_o | ready_i. ready_o = en (combinational). Both stages advance only when en=1. When en=0, all registers hold, so data_o, sat_o and valid_o stay stable.
- Latency: 2 cycles from input handshake to valid_o when ready_i stays high. Throughput is 1 sample/cycle. Bubbles propagate as valid=0.
- Stage 1 (round):
  - Extend data_i to L_WD+1 bits: sign-extend if signed_i=1, zero-extend if signed_i=0.
  - Add 2^(SHIFT-1); add nothing if SHIFT=0.
  - Arithmetic-shift right by SHIFT.
  - Register the result (L_WD+1-SHIFT bits), signed_i and valid_i.
  - Rounding is half-up, toward +inf: +0.5 becomes 1, -0.5 becomes 0. No overflow is possible thanks to the extra bit.
- Stage 2 (saturate):
  - Signed: clamp to [-2^(S_WD-1), 2^(S_WD-1)-1].
  - Unsigned: clamp to [0, 2^S_WD-1].
  - sat_o=1 iff clamping changed the value. Register data_o, sat_o, valid_o.
- signed_i is sampled per sample and travels with that sample. Mixing modes back-to-back is legal.
- Monitor:
  - An event is valid_o & ready_i & sat_o.
  - On an event, sat_sticky_o<=1 and sat_cnt_o<=sat_cnt_o+1, clamped at 2^CNT_WD-1 with no wrap.
  - clr_i alone sets both to 0.
  - clr_i together with an event gives sat_sticky_o=1 and sat_cnt_o=1, so the event is never lost.
- valid_i=1 while ready_o=0: the sample is not taken. The upstream must hold it. Data and valid must stay stable until the handshake completes.

Decomposition:
- Shared package sos_pkg:
  - localparam helpers for the signed/unsigned max/min of a width.
  - A rounding-offset function.
  - The elaboration assertion macro/constants.
- Sub-module sos_saturate: combinational, parameterised by input and output width, with a signed select. It produces the clamped value and the sat flag and is used by stage 2.
- The pipeline and monitor stay in the top module.

Test Plan (L_WD=32, S_WD=16, SHIFT=14, ready_i=1 unless stated):
- Signed rounding:
  - 0x0000_6000 gives 0x0002 two cycles later.
  - 0x0000_2000 gives 0x0001.
  - 0xFFFF_E000 gives 0x0000.
  - 0xFFFF_9FFF gives 0xFFFE.
  - sat_o=0 for all four.
- Signed saturation boundaries:
  - 0x1FFF_DFFF gives 0x7FFF with sat_o=0.
  - 0x1FFF_E000 gives 0x7FFF with sat_o=1.
  - 0x7FFF_FFFF gives 0x7FFF with sat_o=1.
  - 0x8000_0000 gives 0x8000 with sat_o=1.
- Unsigned (signed_i=0):
  - 0x3FFF_C000 gives 0xFFFF with sat_o=0.
  - 0xFFFF_FFFF gives 0xFFFF with sat_o=1.
  - An interleaved signed sample 0xFFFF_C000 gives 0xFFFF with sat_o=0, since -1 is in range.
- Backpressure:
  - Stream 1..6 (values n<<14) and drop ready_i for 3 cycles after the first output.
  - data_o and valid_o must hold, and ready_o=0 while stalled.
  - The output sequence must be exactly 1..6 with no loss or duplicate.
- Monitor with CNT_WD=4:
  - 20 consecutive saturating samples give sat_cnt_o=15 and sat_sticky_o=1.
  - clr_i asserted on a saturated handshake cycle gives sat_cnt_o=1 next cycle.
  - clr_i on an idle cycle gives 0 and sticky 0.
- Reset mid-stream:
  - Assert rst_i asynchronously with both stages full.
  - Outputs must go to 0 immediately, with no stale sample after release.
  - The first post-reset sample 0x0000_4000 gives 0x0001 after 2 cycles.

Source files
------------

// File: rtl/sos_pkg.sv
// Shared constants and helpers for the SOS IIR output quantizer.
package sos_pkg;

    function automatic logic [63:0] smax(input int unsigned w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Two's complement minimum; callers truncate to w bits.
    function automatic logic [63:0] smin(input int unsigned w);
        return 64'd1 << (w - 1);
    endfunction

    function automatic logic [63:0] umax(input int unsigned w);
        return (w >= 64) ? '1 : (64'd1 << w) - 64'd1;
    endfunction

    // Half-LSB offset that turns a floor shift into round-half-up.
    function automatic logic [63:0] round_ofs(input int unsigned shift);
        return (shift == 0) ? 64'd0 : (64'd1 << (shift - 1));
    endfunction

    function automatic bit params_ok(input int unsigned l_wd, input int unsigned s_wd,
                                     input int unsigned shift);
        return (shift < l_wd) && ((l_wd - shift) >= s_wd);
    endfunction

endpackage

// File: rtl/sos_saturate.sv
// Combinational clamp of a wide value into OUT_WD bits, signed or unsigned.
module sos_saturate
    import sos_pkg::*;
#(
    parameter int unsigned IN_WD  = 19,
    parameter int unsigned OUT_WD = 16
) (
    input  logic [IN_WD-1:0]  i_data,
    input  logic              i_signed,
    output logic [OUT_WD-1:0] o_data_c,
    output logic              o_sat_c
);

    localparam logic [OUT_WD-1:0] SMAX = OUT_WD'(smax(OUT_WD));
    localparam logic [OUT_WD-1:0] SMIN = OUT_WD'(smin(OUT_WD));
    localparam logic [OUT_WD-1:0] UMAX = OUT_WD'(umax(OUT_WD));

    logic [IN_WD-OUT_WD:0]   w_hi_s;
    logic [IN_WD-OUT_WD-1:0] w_hi_u;

    assign w_hi_s = i_data[IN_WD-1:OUT_WD-1];
    assign w_hi_u = i_data[IN_WD-1:OUT_WD];

    // Unsigned inputs are never negative here: they are zero-extended before rounding.
    always_comb begin
        o_data_c = i_data[OUT_WD-1:0];
        o_sat_c  = 1'b0;
        if (i_signed) begin
            if (!((&w_hi_s) || !(|w_hi_s))) begin
                o_sat_c  = 1'b1;
                o_data_c = i_data[IN_WD-1] ? SMIN : SMAX;
            end
        end else if (|w_hi_u) begin
            o_sat_c  = 1'b1;
            o_data_c = UMAX;
        end
    end

endmodule

// File: rtl/sos_output_quantize.sv
// Output width reducer for the cascade SOS IIR: round-half-up shift, saturate,
// two-stage valid/ready pipeline and saturation monitor.
module sos_output_quantize
    import sos_pkg::*;
#(
    parameter int unsigned L_WD   = 32,
    parameter int unsigned S_WD   = 16,
    parameter int unsigned SHIFT  = 14,
    parameter int unsigned CNT_WD = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [L_WD-1:0]   data_i,
    input  logic              signed_i,
    input  logic              valid_i,
    output logic              ready_o,
    output logic [S_WD-1:0]   data_o,
    output logic              sat_o,
    output logic              valid_o,
    input  logic              ready_i,
    input  logic              clr_i,
    output logic              sat_sticky_o,
    output logic [CNT_WD-1:0] sat_cnt_o
);

    localparam int unsigned       EXT_WD  = L_WD + 1;
    localparam int unsigned       RND_WD  = L_WD + 1 - SHIFT;
    localparam logic [EXT_WD-1:0] RND_OFS = EXT_WD'(round_ofs(SHIFT));
    localparam logic [CNT_WD-1:0] CNT_MAX = '1;

    if (!params_ok(L_WD, S_WD, SHIFT)) begin : g_bad_params
        $error("sos_output_quantize: need SHIFT < L_WD and L_WD-SHIFT >= S_WD");
    end

    logic              w_en;
    logic [EXT_WD-1:0] w_ext;
    logic [EXT_WD-1:0] w_sum;
    logic [RND_WD-1:0] w_rnd;
    logic [S_WD-1:0]   w_sat_data;
    logic              w_sat;
    logic              w_evt;

    logic [RND_WD-1:0] r_rnd;
    logic              r_sgn1;
    logic              r_vld1;
    logic [S_WD-1:0]   r_data;
    logic              r_sat;
    logic              r_vld2;
    logic              r_sticky;
    logic [CNT_WD-1:0] r_cnt;

    assign w_en    = ~r_vld2 | ready_i;
    assign ready_o = w_en;

    // The extra top bit absorbs the rounding carry; the slice equals the shift
    // result for both modes, the mode only changes how stage 2 reads it.
    assign w_ext = signed_i ? {data_i[L_WD-1], data_i} : {1'b0, data_i};
    assign w_sum = w_ext + RND_OFS;
    assign w_rnd = w_sum[EXT_WD-1:SHIFT];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_rnd  <= '0;
            r_sgn1 <= 1'b0;
            r_vld1 <= 1'b0;
        end else if (w_en) begin
            r_rnd  <= w_rnd;
            r_sgn1 <= signed_i;
            r_vld1 <= valid_i;
        end
    end

    sos_saturate #(
        .IN_WD  (RND_WD),
        .OUT_WD (S_WD)
    ) u_sat (
        .i_data   (r_rnd),
        .i_signed (r_sgn1),
        .o_data_c (w_sat_data),
        .o_sat_c  (w_sat)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_data <= '0;
            r_sat  <= 1'b0;
            r_vld2 <= 1'b0;
        end else if (w_en) begin
            r_data <= w_sat_data;
            r_sat  <= w_sat & r_vld1;
            r_vld2 <= r_vld1;
        end
    end

    assign w_evt = r_vld2 & ready_i & r_sat;

    // A clear coinciding with an event keeps that event.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_sticky <= 1'b0;
            r_cnt    <= '0;
        end else if (clr_i) begin
            r_sticky <= w_evt;
            r_cnt    <= w_evt ? CNT_WD'(1) : '0;
        end else if (w_evt) begin
            r_sticky <= 1'b1;
            if (r_cnt != CNT_MAX) begin
                r_cnt <= r_cnt + CNT_WD'(1);
            end
        end
    end

    assign data_o       = r_data;
    assign sat_o        = r_sat;
    assign valid_o      = r_vld2;
    assign sat_sticky_o = r_sticky;
    assign sat_cnt_o    = r_cnt;

endmodule

// File: tb/tb_sos_output_quantize.sv
// Directed self-checking bench for sos_output_quantize (CNT_WD=4 to reach the clamp).
module tb_sos_output_quantize;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] data_i;
    logic        signed_i;
    logic        valid_i;
    logic        ready_o;
    logic [15:0] data_o;
    logic        sat_o;
    logic        valid_o;
    logic        ready_i;
    logic        clr_i;
    logic        sat_sticky_o;
    logic [3:0]  sat_cnt_o;

    int errors = 0;
    int checks = 0;

    sos_output_quantize #(
        .L_WD   (32),
        .S_WD   (16),
        .SHIFT  (14),
        .CNT_WD (4)
    ) dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .data_i       (data_i),
        .signed_i     (signed_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .sat_o        (sat_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .clr_i        (clr_i),
        .sat_sticky_o (sat_sticky_o),
        .sat_cnt_o    (sat_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached at %0t", $time);
        $fatal(1, "watchdog expired");
    end

    // Presents one sample for one cycle and returns at the negedge where it is on data_o.
    task automatic drive_one(input logic [31:0] d, input logic s);
        @(negedge clk_i);
        data_i   = d;
        signed_i = s;
        valid_i  = 1'b1;
        @(negedge clk_i);
        valid_i  = 1'b0;
        @(negedge clk_i);
    endtask

    task automatic test_reset();
        rst_i = 1'b1; valid_i = 1'b0; data_i = '0; signed_i = 1'b1;
        ready_i = 1'b1; clr_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({valid_o, sat_o, data_o} !== 18'h0)
            $display("FAIL reset_out: got v=%b s=%b d=%h expected v=0 s=0 d=0000", valid_o, sat_o, data_o);
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== 5'h0)
            $display("FAIL reset_mon: got sticky=%b cnt=%0d expected sticky=0 cnt=0", sat_sticky_o, sat_cnt_o);
        checks++;
        if (ready_o !== 1'b1)
            $display("FAIL reset_ready: got %b expected 1", ready_o);
        errors += (({valid_o, sat_o, data_o} !== 18'h0) ? 1 : 0)
                + (({sat_sticky_o, sat_cnt_o} !== 5'h0) ? 1 : 0)
                + ((ready_o !== 1'b1) ? 1 : 0);
        rst_i = 1'b0;
    endtask

    task automatic test_signed_round();
        logic [31:0] vin  [0:3];
        logic [15:0] vexp [0:3];
        vin  = '{32'h0000_6000, 32'h0000_2000, 32'hFFFF_E000, 32'hFFFF_9FFF};
        vexp = '{16'h0002, 16'h0001, 16'h0000, 16'hFFFE};
        for (int i = 0; i < 4; i++) begin
            drive_one(vin[i], 1'b1);
            checks++;
            if ({valid_o, sat_o, data_o} !== {1'b1, 1'b0, vexp[i]}) begin
                errors++;
                $display("FAIL round[%0d]: got v=%b s=%b d=%h expected v=1 s=0 d=%h",
                         i, valid_o, sat_o, data_o, vexp[i]);
            end
        end
    endtask

    task automatic test_signed_sat();
        logic [31:0] vin  [0:3];
        logic [15:0] vexp [0:3];
        logic        vsat [0:3];
        vin  = '{32'h1FFF_DFFF, 32'h1FFF_E000, 32'h7FFF_FFFF, 32'h8000_0000};
        vexp = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h8000};
        vsat = '{1'b0, 1'b1, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            drive_one(vin[i], 1'b1);
            checks++;
            if ({valid_o, sat_o, data_o} !== {1'b1, vsat[i], vexp[i]}) begin
                errors++;
                $display("FAIL ssat[%0d]: got v=%b s=%b d=%h expected v=1 s=%b d=%h",
                         i, valid_o, sat_o, data_o, vsat[i], vexp[i]);
            end
        end
    endtask

    task automatic test_unsigned_mixed();
        drive_one(32'h3FFF_C000, 1'b0);
        checks++;
        if ({valid_o, sat_o, data_o} !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL usat_edge: got v=%b s=%b d=%h expected v=1 s=0 d=ffff", valid_o, sat_o, data_o);
        end
        // Unsigned then signed on consecutive cycles.
        @(negedge clk_i);
        data_i = 32'hFFFF_FFFF; signed_i = 1'b0; valid_i = 1'b1;
        @(negedge clk_i);
        data_i = 32'hFFFF_C000; signed_i = 1'b1;
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if ({valid_o, sat_o, data_o} !== {1'b1, 1'b1, 16'hFFFF}) begin
            errors++;
            $display("FAIL usat_max: got v=%b s=%b d=%h expected v=1 s=1 d=ffff", valid_o, sat_o, data_o);
        end
        @(negedge clk_i);
        checks++;
        if ({valid_o, sat_o, data_o} !== {1'b1, 1'b0, 16'hFFFF}) begin
            errors++;
            $display("FAIL mixed_signed: got v=%b s=%b d=%h expected v=1 s=0 d=ffff", valid_o, sat_o, data_o);
        end
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== {1'b1, 4'd4}) begin
            errors++;
            $display("FAIL mon_count4: got sticky=%b cnt=%0d expected sticky=1 cnt=4", sat_sticky_o, sat_cnt_o);
        end
    endtask

    task automatic test_backpressure();
        int          sent;
        int          stall_left;
        bit          first_seen;
        logic [15:0] rx [$];
        sent = 0; stall_left = 0; first_seen = 1'b0;
        signed_i = 1'b1;
        for (int cyc = 0; cyc < 40 && rx.size() < 6; cyc++) begin
            @(negedge clk_i);
            if (sent < 6) begin
                valid_i = 1'b1;
                data_i  = 32'(sent + 1) << 14;
            end else begin
                valid_i = 1'b0;
            end
            if (stall_left > 0) begin
                ready_i = 1'b0;
                stall_left--;
            end else begin
                ready_i = 1'b1;
            end
            #1;
            if (!ready_i) begin
                checks++;
                if ({ready_o, valid_o, data_o} !== {1'b0, 1'b1, 16'(rx.size() + 1)}) begin
                    errors++;
                    $display("FAIL bp_stall: got rdy=%b v=%b d=%h expected rdy=0 v=1 d=%h",
                             ready_o, valid_o, data_o, 16'(rx.size() + 1));
                end
            end
            if (valid_o && ready_i) begin
                rx.push_back(data_o);
                if (!first_seen) begin
                    first_seen = 1'b1;
                    stall_left = 3;
                end
            end
            if (valid_i && ready_o) sent++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        checks++;
        if (rx.size() != 6) begin
            errors++;
            $display("FAIL bp_count: got %0d outputs expected 6", rx.size());
        end
        for (int i = 0; i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== 16'(i + 1)) begin
                errors++;
                $display("FAIL bp_order[%0d]: got %h expected %h", i, rx[i], 16'(i + 1));
            end
        end
    endtask

    task automatic test_monitor();
        signed_i = 1'b1;
        ready_i  = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            data_i  = 32'h7FFF_FFFF;
            valid_i = 1'b1;
        end
        @(negedge clk_i);
        valid_i = 1'b0;
        repeat (3) @(negedge clk_i);
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== {1'b1, 4'hF}) begin
            errors++;
            $display("FAIL mon_clamp: got sticky=%b cnt=%0d expected sticky=1 cnt=15", sat_sticky_o, sat_cnt_o);
        end
        drive_one(32'h7FFF_FFFF, 1'b1);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== {1'b1, 4'd1}) begin
            errors++;
            $display("FAIL mon_clr_evt: got sticky=%b cnt=%0d expected sticky=1 cnt=1", sat_sticky_o, sat_cnt_o);
        end
        @(negedge clk_i);
        clr_i = 1'b1;
        @(negedge clk_i);
        clr_i = 1'b0;
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== 5'h0) begin
            errors++;
            $display("FAIL mon_clr_idle: got sticky=%b cnt=%0d expected sticky=0 cnt=0", sat_sticky_o, sat_cnt_o);
        end
    endtask

    task automatic test_reset_midstream();
        signed_i = 1'b1;
        @(negedge clk_i);
        data_i = 32'h7FFF_FFFF; valid_i = 1'b1;
        @(negedge clk_i);
        data_i = 32'h8000_0000;
        @(negedge clk_i);
        valid_i = 1'b0;
        checks++;
        if ({valid_o, sat_o, data_o} !== {1'b1, 1'b1, 16'h7FFF}) begin
            errors++;
            $display("FAIL mid_full: got v=%b s=%b d=%h expected v=1 s=1 d=7fff", valid_o, sat_o, data_o);
        end
        #2 rst_i = 1'b1;
        #1;
        checks++;
        if ({valid_o, sat_o, data_o} !== 18'h0) begin
            errors++;
            $display("FAIL mid_async: got v=%b s=%b d=%h expected v=0 s=0 d=0000", valid_o, sat_o, data_o);
        end
        repeat (2) @(negedge clk_i);
        rst_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            checks++;
            if (valid_o !== 1'b0) begin
                errors++;
                $display("FAIL mid_stale[%0d]: got valid=%b expected 0", i, valid_o);
            end
        end
        checks++;
        if ({sat_sticky_o, sat_cnt_o} !== 5'h0) begin
            errors++;
            $display("FAIL mid_mon: got sticky=%b cnt=%0d expected sticky=0 cnt=0", sat_sticky_o, sat_cnt_o);
        end
        drive_one(32'h0000_4000, 1'b1);
        checks++;
        if ({valid_o, sat_o, data_o} !== {1'b1, 1'b0, 16'h0001}) begin
            errors++;
            $display("FAIL mid_first: got v=%b s=%b d=%h expected v=1 s=0 d=0001", valid_o, sat_o, data_o);
        end
    endtask

    initial begin
        test_reset();
        test_signed_round();
        test_signed_sat();
        test_unsigned_mixed();
        test_backpressure();
        test_monitor();
        test_reset_midstream();
        @(negedge clk_i);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
